// File: rtl/tt_sweep_pkg.sv
// Shared constants, state encoding and width helper for the truth-table sweep/capture stage.
package tt_sweep_pkg;

  localparam int N_IN  = 7;
  localparam int TT_W  = 1 << N_IN;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_sweep_capture.sv
// Sweeps all input patterns of an N_IN-input function block, captures its truth table,
// counts mismatches against a reference table and offers the result on a valid/ready handshake.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TT_W-1:0]   expected_i,
  output logic [N_IN-1:0]   x_o,
  input  logic              f_i,
  output logic              busy,
  output logic [TT_W-1:0]   tt_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              match_o,
  output logic              tt_valid,
  input  logic              tt_ready
);

  localparam int              CW          = cnt_width(SETTLE);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;

  state_t            state, state_d;
  logic [N_IN-1:0]   idx;
  logic [CW-1:0]     settle_cnt;
  logic [TT_W-1:0]   expected_q;
  logic              capture;
  logic              err_bit;
  logic [ERR_W-1:0]  err_next;

  assign x_o  = idx;
  assign busy = (state != IDLE);

  assign err_bit  = f_i ^ expected_q[idx];
  assign err_next = err_cnt_o + ERR_W'(err_bit);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    case (state)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        capture = (settle_cnt == SETTLE_LAST);
        if (capture && (idx == IDX_LAST)) state_d = DONE;
      end
      DONE:  if (tt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      tt_o       <= '0;
      err_cnt_o  <= '0;
      match_o    <= 1'b0;
      tt_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tt_o       <= '0;
          err_cnt_o  <= '0;
          match_o    <= 1'b0;
          idx        <= '0;
          settle_cnt <= '0;
        end
        SWEEP: if (capture) begin
          tt_o[idx]  <= f_i;
          err_cnt_o  <= err_next;
          idx        <= idx + 1'b1;
          settle_cnt <= '0;
          // Last pattern: the match flag must include this final bit's contribution.
          if (idx == IDX_LAST) begin
            tt_valid <= 1'b1;
            match_o  <= (err_next == '0);
          end
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
        DONE: if (tt_ready) tt_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: the reference table has no reset; it is always loaded on an accepted start before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) expected_q <= expected_i;
  end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: two instances (SETTLE=1 and SETTLE=3) driven by a table-based function model.
module tb_tt_sweep_capture;
  import tt_sweep_pkg::*;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   err;
    logic         match;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         tt_ready = 1'b0;
  logic         sel = 1'b0;
  logic [127:0] expected = '0;
  logic [127:0] func_tt = '0;

  logic         start_a, start_b, ready_a, ready_b, f_a, f_b;
  logic [6:0]   x_a, x_b;
  logic         busy_a, busy_b, match_a, match_b, valid_a, valid_b;
  logic [127:0] tt_a, tt_b;
  logic [7:0]   err_a, err_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign ready_a = tt_ready & ~sel;
  assign ready_b = tt_ready & sel;
  assign f_a     = func_tt[x_a];
  assign f_b     = func_tt[x_b];

  tt_sweep_capture #(.SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected_i(expected), .x_o(x_a), .f_i(f_a),
    .busy(busy_a), .tt_o(tt_a), .err_cnt_o(err_a), .match_o(match_a),
    .tt_valid(valid_a), .tt_ready(ready_a)
  );

  tt_sweep_capture #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected_i(expected), .x_o(x_b), .f_i(f_b),
    .busy(busy_b), .tt_o(tt_b), .err_cnt_o(err_b), .match_o(match_b),
    .tt_valid(valid_b), .tt_ready(ready_b)
  );

  wire [6:0]   obs_x     = sel ? x_b     : x_a;
  wire         obs_busy  = sel ? busy_b  : busy_a;
  wire [127:0] obs_tt    = sel ? tt_b    : tt_a;
  wire [7:0]   obs_err   = sel ? err_b   : err_a;
  wire         obs_match = sel ? match_b : match_a;
  wire         obs_valid = sel ? valid_b : valid_a;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] f, input logic [127:0] e);
    exp_t x;
    x.tt    = f;
    x.err   = 8'($countones(f ^ e));
    x.match = (f == e);
    sb.push_back(x);
  endtask

  // Loads the function/reference tables, queues the expected result and pulses start (edge T).
  task automatic start_sweep(input logic [127:0] f, input logic [127:0] e);
    func_tt  = f;
    expected = e;
    push_exp(f, e);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs_busy !== 1'b1 || obs_x !== 7'd0) begin
      errors++;
      $display("FAIL start_accept: busy=%b x=%0d, required busy=1 x=0", obs_busy, obs_x);
    end
  endtask

  // Waits (bounded) for tt_valid, checks latency and per-pattern hold time, then pops the scoreboard.
  task automatic wait_result(input int settle);
    int         n = 0;
    int         bad = 0;
    int         run = 1;
    logic [6:0] prev = obs_x;
    exp_t       e;
    while (!obs_valid && n < 128 * settle + 20) begin
      tick();
      n++;
      if (obs_x == prev) run++;
      else begin
        if (run != settle) bad++;
        run  = 1;
        prev = obs_x;
      end
    end
    checks++;
    if (obs_valid !== 1'b1 || n != 128 * settle) begin
      errors++;
      $display("FAIL latency: valid=%b after %0d cycles, required valid=1 after %0d", obs_valid, n, 128 * settle);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL x_hold: %0d patterns not held for %0d cycles, required 0", bad, settle);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty at result, required one entry");
    end else begin
      e = sb.pop_front();
      if (obs_tt !== e.tt || obs_err !== e.err || obs_match !== e.match || obs_x !== 7'd0 || obs_busy !== 1'b1) begin
        errors++;
        $display("FAIL result: tt=%h err=%0d match=%b x=%0d busy=%b, required tt=%h err=%0d match=%b x=0 busy=1",
                 obs_tt, obs_err, obs_match, obs_x, obs_busy, e.tt, e.err, e.match);
      end
    end
  endtask

  task automatic handshake();
    logic [127:0] tt_h  = obs_tt;
    logic [7:0]   err_h = obs_err;
    tt_ready = 1'b1;
    tick();
    tt_ready = 1'b0;
    checks++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_tt !== tt_h || obs_err !== err_h) begin
      errors++;
      $display("FAIL handshake: valid=%b busy=%b tt=%h err=%0d, required valid=0 busy=0 tt=%h err=%0d",
               obs_valid, obs_busy, obs_tt, obs_err, tt_h, err_h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (obs_x !== 7'd0 || obs_tt !== '0 || obs_err !== 8'd0 || obs_match !== 1'b0 ||
          obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state(dut %0d): x=%0d tt=%h err=%0d match=%b valid=%b busy=%b, required all 0",
                 s, obs_x, obs_tt, obs_err, obs_match, obs_valid, obs_busy);
      end
    end
    sel = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_majority();
    logic [127:0] maj;
    for (int i = 0; i < 128; i++) maj[i] = (int'(i[0]) + int'(i[3]) + int'(i[4])) >= 2;
    sel = 1'b0;
    start_sweep(maj, maj);
    wait_result(1);
    handshake();
  endtask

  task automatic test_table();
    logic [127:0] t = 128'hfeeaeaeafea8aa80feaaea80a8a8a880;
    sel = 1'b0;
    start_sweep(t, t);
    // Reference changes after start must not affect the running sweep.
    expected = ~t;
    wait_result(1);
    handshake();
    start_sweep(t, t ^ 128'h1);
    wait_result(1);
    handshake();
  endtask

  task automatic test_settle3();
    sel = 1'b1;
    #1;
    start_sweep('1, '0);
    wait_result(3);
    handshake();
    sel = 1'b0;
    #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] f = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] tt_h;
    logic [7:0]   err_h;
    logic         match_h;
    int           unstable = 0;
    sel = 1'b0;
    start_sweep(f, f ^ (128'h9 << 40));
    wait_result(1);
    tt_h = obs_tt;
    err_h = obs_err;
    match_h = obs_match;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick();
      if (obs_tt !== tt_h || obs_err !== err_h || obs_match !== match_h ||
          obs_valid !== 1'b1 || obs_busy !== 1'b1 || obs_x !== 7'd0) unstable++;
    end
    start = 1'b0;
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, required 0", unstable);
    end
    handshake();
    start_sweep(~f, ~f);
    wait_result(1);
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [127:0] f = {$urandom, $urandom, $urandom, $urandom};
    sel = 1'b0;
    func_tt  = f;
    expected = f;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    checks++;
    if (obs_x !== 7'd60) begin
      errors++;
      $display("FAIL mid_index: x=%0d, required 60", obs_x);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs_x !== 7'd0 || obs_tt !== '0 || obs_err !== 8'd0 || obs_match !== 1'b0 ||
        obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: x=%0d tt=%h err=%0d match=%b valid=%b busy=%b, required all 0",
               obs_x, obs_tt, obs_err, obs_match, obs_valid, obs_busy);
    end
    start_sweep(f, f ^ 128'h3);
    wait_result(1);
    handshake();
  endtask

  task automatic test_start_held();
    logic [127:0] f = {$urandom, $urandom, $urandom, $urandom};
    sel = 1'b0;
    func_tt  = f;
    expected = f;
    push_exp(f, f);
    start = 1'b1;
    tick();
    wait_result(1);
    tt_ready = 1'b1;
    tick();
    tt_ready = 1'b0;
    checks++;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_start_done_edge: busy=%b valid=%b, required busy=0 valid=0", obs_busy, obs_valid);
    end
    push_exp(f, f);
    tick();
    start = 1'b0;
    checks++;
    if (obs_busy !== 1'b1 || obs_x !== 7'd0 || obs_tt !== '0) begin
      errors++;
      $display("FAIL held_start_from_idle: busy=%b x=%0d tt=%h, required busy=1 x=0 tt=0", obs_busy, obs_x, obs_tt);
    end
    wait_result(1);
    handshake();
    tick();
    checks++;
    if (obs_busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL final_idle: busy=%b queue=%0d, required busy=0 queue=0", obs_busy, sb.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_majority();
    test_table();
    test_settle3();
    test_backpressure();
    test_reset_mid();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
